// File: rtl/div_sched_if.sv
// Request/response bundle for the shared divide scheduler.
// master = requesters plus result consumer, slave = div_sched.
interface div_sched_if #(
  parameter int WIDTH = 4
);
  // A transfer happens on a rising edge where valid and ready are both high.
  // Valid never waits on ready. Payload is only meaningful while valid is high.
  // The response payload is held stable while rsp_valid is high and rsp_ready is low.
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_dividend;
  logic [2*WIDTH-1:0] req_divisor;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_quotient;
  logic [WIDTH-1:0]   rsp_remainder;
  logic               rsp_error;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error
  );
endinterface

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one restoring divider between two requesters.
// One quotient bit per clock; a zero divisor returns the saturated all-ones error result.
module div_sched #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  div_sched_if.slave  bus,
  output logic        busy,
  output logic [1:0]  state_dbg
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             ptr;
  logic             id_r;
  logic             err_r;
  logic             valid_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt;

  logic             gnt_any;
  logic             gnt;
  logic [WIDTH-1:0] g_dvd;
  logic [WIDTH-1:0] g_dvs;
  logic [WIDTH:0]   p;
  logic [WIDTH+1:0] diff;

  // Pointer requester wins when valid, otherwise the other one.
  always_comb begin
    gnt_any = 1'b0;
    gnt     = ptr;
    if (bus.req_valid[ptr]) begin
      gnt_any = 1'b1;
      gnt     = ptr;
    end else if (bus.req_valid[~ptr]) begin
      gnt_any = 1'b1;
      gnt     = ~ptr;
    end
  end

  assign g_dvd = gnt ? bus.req_dividend[2*WIDTH-1:WIDTH] : bus.req_dividend[WIDTH-1:0];
  assign g_dvs = gnt ? bus.req_divisor[2*WIDTH-1:WIDTH]  : bus.req_divisor[WIDTH-1:0];

  assign bus.req_ready = (state == IDLE && !rst && gnt_any) ? (2'b01 << gnt) : 2'b00;

  // Restoring step: a borrow out of the trial subtraction means keep P.
  assign p    = {a_r, q_r[WIDTH-1]};
  assign diff = {1'b0, p} - {2'b00, d_r};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      id_r    <= 1'b0;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
      q_r     <= '0;
      a_r     <= '0;
      d_r     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            ptr  <= ~gnt;
            id_r <= gnt;
            cnt  <= '0;
            if (g_dvs == '0) begin
              q_r     <= '1;
              a_r     <= '1;
              err_r   <= 1'b1;
              valid_r <= 1'b1;
              state   <= DONE;
            end else begin
              q_r   <= g_dvd;
              d_r   <= g_dvs;
              a_r   <= '0;
              err_r <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!diff[WIDTH+1]) begin
            a_r <= diff[WIDTH-1:0];
            q_r <= {q_r[WIDTH-2:0], 1'b1};
          end else begin
            a_r <= p[WIDTH-1:0];
            q_r <= {q_r[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            valid_r <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            valid_r <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid     = valid_r;
  assign bus.rsp_id        = id_r;
  assign bus.rsp_quotient  = q_r;
  assign bus.rsp_remainder = a_r;
  assign bus.rsp_error     = err_r;
  assign busy              = (state != IDLE);
  assign state_dbg         = state;
endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: drivers push expected results, a monitor pops on each response.
module tb_div_sched;
  logic       clk;
  logic       rst;
  logic       busy;
  logic [1:0] state_dbg;
  logic       rv0, rv1, rdy;
  logic [3:0] dvd0, dvd1, dvs0, dvs1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cyc = 0;
  int acc_cyc = 0;
  logic [9:0] exp_q[$];
  int grant_q[$];

  div_sched_if #(.WIDTH(4)) bus ();

  assign bus.req_valid    = {rv1, rv0};
  assign bus.req_dividend = {dvd1, dvd0};
  assign bus.req_divisor  = {dvs1, dvs0};
  assign bus.rsp_ready    = rdy;

  div_sched #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: raise valid, wait for grant, push expected, release and scramble operands
  task automatic drive_req(input int id, input logic [3:0] a, input logic [3:0] b,
                           input logic [9:0] e);
    int n = 0;
    bit got = 0;
    if (id == 0) begin rv0 = 1'b1; dvd0 = a; dvs0 = b; end
    else         begin rv1 = 1'b1; dvd1 = a; dvs1 = b; end
    while (!got && n < 200) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        got = 1;
        exp_q.push_back(e);
        grant_q.push_back(id);
        acc_cyc = cyc + 1;
      end
      n++;
    end
    if (!got) chk("accept_timeout", id, -1);
    @(posedge clk);
    #1;
    if (id == 0) begin rv0 = 1'b0; dvd0 = 4'($urandom); dvs0 = 4'($urandom); end
    else         begin rv1 = 1'b0; dvd1 = 4'($urandom); dvs1 = 4'($urandom); end
  endtask

  task automatic measure_lat(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      chk("busy_pending", busy, 1);
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] golden(input int id, input logic [3:0] a, input logic [3:0] b);
    if (b == 4'd0) return {id[0], 1'b1, 4'hF, 4'hF};
    return {id[0], 1'b0, 4'(a / b), 4'(a % b)};
  endfunction

  // monitor / scoreboard
  initial begin
    logic [9:0] cur, held, e;
    bit prev_stall, prev_hs;
    prev_stall = 0;
    prev_hs = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        prev_hs = 0;
      end else begin
        cur = {bus.rsp_id, bus.rsp_error, bus.rsp_quotient, bus.rsp_remainder};
        if (prev_hs) chk("rsp_pulse", bus.rsp_valid, 0);
        if (prev_stall) begin
          chk("valid_hold", bus.rsp_valid, 1);
          chk("rsp_hold", cur, held);
        end
        prev_hs = 0;
        prev_stall = 0;
        if (bus.rsp_valid) begin
          if (rdy) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", cur, -1);
            else begin
              e = exp_q.pop_front();
              chk("rsp_data", cur, e);
            end
            hs_cyc = cyc + 1;
            prev_hs = 1;
          end else begin
            prev_stall = 1;
            held = cur;
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    int n;
    bit sweep_on;
    rst = 1'b1; rv0 = 1'b1; rv1 = 1'b1; rdy = 1'b0;
    dvd0 = 4'd3; dvs0 = 4'd1; dvd1 = 4'd5; dvs1 = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_rsp_word", {bus.rsp_id, bus.rsp_error, bus.rsp_quotient, bus.rsp_remainder}, 0);
    rv0 = 1'b0; rv1 = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;

    // single request 13/4, then backpressure with a queued request 6/2
    drive_req(0, 4'd13, 4'd4, {1'b0, 1'b0, 4'd3, 4'd1});
    measure_lat(n);
    chk("lat_nonzero", n, 4);
    fork
      drive_req(1, 4'd6, 4'd2, {1'b1, 1'b0, 4'd3, 4'd0});
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_req_ready", bus.req_ready, 0);
          chk("stall_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        rdy = 1'b1;
      end
    join
    chk("accept_after_hs", acc_cyc, hs_cyc + 1);
    wait_drain();
    chk("idle_busy", busy, 0);

    // divide by zero from requester 1
    rdy = 1'b0;
    drive_req(1, 4'd9, 4'd0, {1'b1, 1'b1, 4'd15, 4'd15});
    chk("zero_state_done", state_dbg, 2);
    measure_lat(n);
    chk("lat_zero", n, 0);
    repeat (2) @(posedge clk);
    #1;
    rdy = 1'b1;
    wait_drain();

    // both requesters continuously valid
    grant_q.delete();
    fork
      begin repeat (2) drive_req(0, 4'd15, 4'd1, {1'b0, 1'b0, 4'd15, 4'd0}); end
      begin repeat (2) drive_req(1, 4'd7, 4'd7, {1'b1, 1'b0, 4'd1, 4'd0}); end
    join
    wait_drain();
    chk("grant_count", grant_q.size(), 4);
    for (int i = 0; i < grant_q.size() && i < 4; i++) chk("grant_alt", grant_q[i], i % 2);

    // reset two cycles into CALC
    drive_req(0, 4'd11, 4'd3, {1'b0, 1'b0, 4'd3, 4'd2});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; rv0 = 1'b1; rv1 = 1'b1;
    @(negedge clk);
    chk("rst_mid_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
    chk("rst_mid_valid", bus.rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    void'(exp_q.pop_back());
    repeat (8) begin
      @(negedge clk);
      chk("no_stale", bus.rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    grant_q.delete();
    fork
      drive_req(0, 4'd8, 4'd2, {1'b0, 1'b0, 4'd4, 4'd0});
      drive_req(1, 4'd5, 4'd3, {1'b1, 1'b0, 4'd1, 4'd2});
    join
    wait_drain();
    chk("rst_ptr_first", (grant_q.size() > 0) ? grant_q[0] : -1, 0);

    // exhaustive sweep with random response stalls
    sweep_on = 1;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          logic [7:0] v;
          v = 8'(i);
          drive_req(i % 2, v[7:4], v[3:0], golden(i % 2, v[7:4], v[3:0]));
        end
        sweep_on = 0;
      end
      begin
        while (sweep_on) begin
          @(posedge clk);
          #1;
          rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rdy = 1'b1;
    wait_drain();
    chk("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
